// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampled UART receiver (DBIT data bits LSB first, one stop bit by default).
// Optional build macro UART_RX_PARITY_EN inserts an even-parity bit between data and stop and drives parity_err.
module uart_rx_oversample #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 54
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);
  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DVSR - 1);
  localparam logic [3:0]    MID_TICK  = 4'd7;
  localparam logic [3:0]    LAST_TICK = 4'd15;
  localparam logic [3:0]    STOP_TICK = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t          r_state;
  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            r_rx_prev;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            w_tick;
  logic            w_fall;
  assign w_tick       = (r_cnt == CNT_MAX);
  assign w_fall       = r_rx_prev & ~r_rx_sync;
  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  logic r_perr;
  logic r_perr_pend;
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif
  // two-flop synchroniser plus one delayed copy for start-edge detection; idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end
  // free-running oversampling tick generator, never realigned to a frame
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
  end
  // frame FSM: start edge, mid-start check, data shift, optional parity, stop and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr      <= 1'b0;
      r_perr_pend <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_s == MID_TICK) begin
              r_s     <= '0;
              r_n     <= '0;
              r_state <= r_rx_sync ? IDLE : DATA;
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_s == LAST_TICK) begin
              r_s <= '0;
              r_b <= {r_rx_sync, r_b[DBIT-1:1]};
              if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            if (r_s == LAST_TICK) begin
              r_s         <= '0;
              r_perr_pend <= (r_rx_sync != ^r_b);
              r_state     <= STOP;
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            if (r_s == STOP_TICK) begin
              r_s     <= '0;
              r_dout  <= r_b;
              r_ferr  <= ~r_rx_sync;
              r_done  <= 1'b1;
              r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
              r_perr  <= r_perr_pend;
`endif
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
